// File: rtl/alu_issue.sv
// alu_issue: operand-issue and writeback stage that owns the register file and PSR
// and feeds the external alu datapath through a 3-state IDLE/EXEC/WB sequence.
module alu_issue #(
   parameter int NREGS = 16,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [15:0]  instr,
   input  logic         instr_valid,
   output logic         instr_ready,
   output logic [W-1:0] alu_dst,
   output logic [W-1:0] alu_src,
   output logic [3:0]   alu_oper,
   output logic [3:0]   alu_func,
   output logic [3:0]   alu_cond,
   output logic [4:0]   alu_condIn,
   input  logic [W-1:0] alu_result,
   input  logic [4:0]   alu_condOut,
   input  logic [4:0]   alu_condWr,
   output logic         done,
   output logic         illegal,
   output logic [4:0]   psr,
   input  logic [3:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   localparam logic [3:0] OP_REG     = 4'h0;
   localparam logic [3:0] OP_SPECIAL = 4'h4;
   localparam logic [3:0] OP_ADDI    = 4'h5;
   localparam logic [3:0] OP_ADDCI   = 4'h7;
   localparam logic [3:0] OP_SHIFT   = 4'h8;
   localparam logic [3:0] OP_SUBI    = 4'h9;
   localparam logic [3:0] OP_SUBCI   = 4'hA;
   localparam logic [3:0] OP_CMPI    = 4'hB;
   localparam logic [3:0] OP_BCOND   = 4'hC;
   localparam logic [3:0] OP_MULI    = 4'hE;
   localparam logic [3:0] FN_TEST    = 4'h8;
   localparam logic [3:0] FN_CMP     = 4'hB;
   localparam logic [3:0] FN_SCOND   = 4'hD;
   state_t       state_q;
   logic [W-1:0] regs_q [NREGS];
   logic [15:0]  instr_q;
   logic [W-1:0] dst_q, src_q, src_d;
   logic [3:0]   oper_q, func_q, cond_q, cond_d;
   logic [4:0]   psr_q;
   logic         done_q, illegal_q, legal, wr_reg;
   logic [3:0]   in_op, in_fn, op, fn;
   logic [W-1:0] imm_z, imm_s, sh, rs;
   assign in_op = instr[15:12];
   assign in_fn = instr[7:4];
   assign legal = (in_op == OP_BCOND)   ? 1'b0 :
                  (in_op == OP_SPECIAL) ? (in_fn == FN_SCOND) :
                  (in_op == OP_SHIFT)   ? (in_fn inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6}) :
                  (in_op == OP_REG)     ? (in_fn inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7,
                                                         4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE}) :
                  1'b1;
   assign op    = instr_q[15:12];
   assign fn    = instr_q[7:4];
   assign imm_z = {{(W-8){1'b0}}, instr_q[7:0]};
   assign imm_s = {{(W-8){instr_q[7]}}, instr_q[7:0]};
   assign sh    = {{(W-4){1'b0}}, instr_q[3:0]};
   assign rs    = regs_q[instr_q[3:0]];
   // Right shifts hand the ALU a negative count; it negates src[4:0] itself.
   assign src_d = (op == OP_SPECIAL) ? '0 :
                  (op == OP_SHIFT)   ? (fn[2] ? rs : fn[0] ? '0 - sh : sh) :
                  (op == OP_REG)     ? rs :
                  (op inside {OP_ADDI, OP_ADDCI, OP_SUBI, OP_SUBCI, OP_CMPI, OP_MULI}) ? imm_s :
                  imm_z;
   assign cond_d = (op == OP_SPECIAL) ? instr_q[3:0] : instr_q[11:8];
   assign wr_reg = !((op == OP_CMPI) || ((op == OP_REG) && ((fn == FN_CMP) || (fn == FN_TEST))));
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         dst_q     <= '0;
         src_q     <= '0;
         oper_q    <= '0;
         func_q    <= '0;
         cond_q    <= '0;
         psr_q     <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: if (instr_valid) begin
               if (legal) begin
                  instr_q <= instr;
                  state_q <= EXEC;
               end else illegal_q <= 1'b1;
            end
            EXEC: begin
               oper_q  <= op;
               func_q  <= fn;
               cond_q  <= cond_d;
               dst_q   <= regs_q[instr_q[11:8]];
               src_q   <= src_d;
               state_q <= WB;
            end
            WB: begin
               if (wr_reg) regs_q[instr_q[11:8]] <= alu_result;
               psr_q   <= (alu_condWr & alu_condOut) | (~alu_condWr & psr_q);
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign instr_ready = (state_q == IDLE);
   assign alu_dst     = dst_q;
   assign alu_src     = src_q;
   assign alu_oper    = oper_q;
   assign alu_func    = func_q;
   assign alu_cond    = cond_q;
   assign alu_condIn  = psr_q;
   assign psr         = psr_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign dbg_data    = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table of instructions with a stub ALU response per entry; expected
// operands and commit state go through a scoreboard popped on done/illegal.
module tb_alu_issue;
   typedef struct {
      logic [15:0] instr;
      logic [15:0] res;
      logic [4:0]  co, cw;
      logic        ill;
      logic [15:0] d, s;
      logic [3:0]  c, rd;
      logic [15:0] rv;
      logic [4:0]  ps;
   } vec_t;
   logic        clk, reset, instr_valid, instr_ready, done, illegal;
   logic [15:0] instr, alu_dst, alu_src, alu_result, dbg_data;
   logic [3:0]  alu_oper, alu_func, alu_cond, dbg_addr;
   logic [4:0]  alu_condIn, alu_condOut, alu_condWr, psr;
   int          n_cmp = 0, n_bad = 0;
   vec_t        tbl[$], sb[$], mv;
   alu_issue dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_dst(alu_dst), .alu_src(alu_src),
      .alu_oper(alu_oper), .alu_func(alu_func), .alu_cond(alu_cond),
      .alu_condIn(alu_condIn), .alu_result(alu_result), .alu_condOut(alu_condOut),
      .alu_condWr(alu_condWr), .done(done), .illegal(illegal), .psr(psr),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic vec_t mk(input logic [15:0] i, res, input logic [4:0] co, cw,
                               input logic il, input logic [15:0] d, s,
                               input logic [3:0] c, rd, input logic [15:0] rv,
                               input logic [4:0] ps);
      vec_t v;
      v.instr = i; v.res = res; v.co = co; v.cw = cw; v.ill = il;
      v.d = d; v.s = s; v.c = c; v.rd = rd; v.rv = rv; v.ps = ps;
      return v;
   endfunction
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic stub(input vec_t v);
      alu_result = v.res; alu_condOut = v.co; alu_condWr = v.cw; dbg_addr = v.rd;
   endtask
   task automatic wait_drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 12) begin @(negedge clk); n++; end
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: timeout, %0d results outstanding, expected 0", nm, sb.size());
         sb.delete();
      end
   endtask
   task automatic issue(input vec_t v);
      int n = 0;
      stub(v);
      @(negedge clk);
      while (!instr_ready && n < 12) begin @(negedge clk); n++; end
      chk($sformatf("ready_%h", v.instr), 16'(instr_ready), 16'd1);
      sb.push_back(v);
      instr = v.instr; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0; instr = 16'($urandom);
      wait_drain($sformatf("drain_%h", v.instr));
   endtask
   always @(negedge clk) begin
      if (done || illegal) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_commit: done=%b illegal=%b, expected nothing outstanding", done, illegal);
         end else begin
            mv = sb.pop_front();
            chk($sformatf("kind_%h", mv.instr), 16'(illegal), 16'(mv.ill));
            if (!mv.ill) begin
               chk($sformatf("dst_%h", mv.instr), alu_dst, mv.d);
               chk($sformatf("src_%h", mv.instr), alu_src, mv.s);
               chk($sformatf("cond_%h", mv.instr), 16'(alu_cond), 16'(mv.c));
               chk($sformatf("oper_%h", mv.instr), 16'(alu_oper), 16'(mv.instr[15:12]));
               chk($sformatf("func_%h", mv.instr), 16'(alu_func), 16'(mv.instr[7:4]));
            end
            chk($sformatf("reg_%h", mv.instr), dbg_data, mv.rv);
            chk($sformatf("psr_%h", mv.instr), 16'(psr), 16'(mv.ps));
            chk($sformatf("condIn_%h", mv.instr), 16'(alu_condIn), 16'(mv.ps));
         end
      end
   end
   initial begin
      tbl.push_back(mk(16'h637F, 16'h007F, 5'b00000, 5'b00000, 0, 16'h0000, 16'h007F, 4'h3, 4'h3, 16'h007F, 5'b00000));
      tbl.push_back(mk(16'hF17F, 16'h7F00, 5'b00000, 5'b00000, 0, 16'h0000, 16'h007F, 4'h1, 4'h1, 16'h7F00, 5'b00000));
      tbl.push_back(mk(16'h21FF, 16'h7FFF, 5'b00000, 5'b00000, 0, 16'h7F00, 16'h00FF, 4'h1, 4'h1, 16'h7FFF, 5'b00000));
      tbl.push_back(mk(16'hD201, 16'h0001, 5'b00000, 5'b00000, 0, 16'h0000, 16'h0001, 4'h2, 4'h2, 16'h0001, 5'b00000));
      tbl.push_back(mk(16'h0251, 16'h8000, 5'b01101, 5'b10111, 0, 16'h0001, 16'h7FFF, 4'h2, 4'h2, 16'h8000, 5'b00101));
      tbl.push_back(mk(16'hD200, 16'h0000, 5'b00000, 5'b00000, 0, 16'h8000, 16'h0000, 4'h2, 4'h2, 16'h0000, 5'b00101));
      tbl.push_back(mk(16'hB2FF, 16'h1234, 5'b01000, 5'b01011, 0, 16'h0000, 16'hFFFF, 4'h2, 4'h2, 16'h0000, 5'b01100));
      tbl.push_back(mk(16'hD480, 16'h0080, 5'b00000, 5'b00000, 0, 16'h0000, 16'h0080, 4'h4, 4'h4, 16'h0080, 5'b01100));
      tbl.push_back(mk(16'h8413, 16'h0010, 5'b00000, 5'b00000, 0, 16'h0080, 16'hFFFD, 4'h4, 4'h4, 16'h0010, 5'b01100));
      tbl.push_back(mk(16'hB000, 16'h5555, 5'b00010, 5'b01011, 0, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0000, 5'b00110));
      tbl.push_back(mk(16'h45D0, 16'h0001, 5'b00000, 5'b00000, 0, 16'h0000, 16'h0000, 4'h0, 4'h5, 16'h0001, 5'b00110));
      tbl.push_back(mk(16'h57FE, 16'hFFFE, 5'b00001, 5'b10111, 0, 16'h0000, 16'hFFFE, 4'h7, 4'h7, 16'hFFFE, 5'b00001));
      tbl.push_back(mk(16'h9780, 16'h007E, 5'b00000, 5'b00000, 0, 16'hFFFE, 16'hFF80, 4'h7, 4'h7, 16'h007E, 5'b00001));
      tbl.push_back(mk(16'h3780, 16'h00FE, 5'b00000, 5'b00000, 0, 16'h007E, 16'h0080, 4'h7, 4'h7, 16'h00FE, 5'b00001));
      tbl.push_back(mk(16'h8402, 16'h0040, 5'b00000, 5'b00000, 0, 16'h0010, 16'h0002, 4'h4, 4'h4, 16'h0040, 5'b00001));
      tbl.push_back(mk(16'h8441, 16'h0123, 5'b00000, 5'b00000, 0, 16'h0040, 16'h7FFF, 4'h4, 4'h4, 16'h0123, 5'b00001));
      tbl.push_back(mk(16'h0384, 16'hBEEF, 5'b00010, 5'b00010, 0, 16'h007F, 16'h0123, 4'h3, 4'h3, 16'h007F, 5'b00011));
      tbl.push_back(mk(16'h07B3, 16'hAAAA, 5'b00000, 5'b01011, 0, 16'h00FE, 16'h007F, 4'h7, 4'h7, 16'h00FE, 5'b00000));
      tbl.push_back(mk(16'hD011, 16'h0011, 5'b00000, 5'b00000, 0, 16'h0000, 16'h0011, 4'h0, 4'h0, 16'h0011, 5'b00000));
      foreach (tbl[i]) ;
      tbl.push_back(mk(16'hC000, 16'hFFFF, 5'b11111, 5'b11111, 1, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0011, 5'b00000));
      tbl.push_back(mk(16'h4100, 16'hFFFF, 5'b11111, 5'b11111, 1, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0011, 5'b00000));
      tbl.push_back(mk(16'h4140, 16'hFFFF, 5'b11111, 5'b11111, 1, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0011, 5'b00000));
      tbl.push_back(mk(16'h4180, 16'hFFFF, 5'b11111, 5'b11111, 1, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0011, 5'b00000));
      tbl.push_back(mk(16'h41C0, 16'hFFFF, 5'b11111, 5'b11111, 1, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0011, 5'b00000));
      tbl.push_back(mk(16'h8150, 16'hFFFF, 5'b11111, 5'b11111, 1, 16'h0, 16'h0, 4'h0, 4'h0, 16'h0011, 5'b00000));
      reset = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
      alu_result = '0; alu_condOut = '0; alu_condWr = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", 16'(instr_ready), 16'd1);
      chk("rst_psr", 16'(psr), 16'd0);
      chk("rst_done", 16'({done, illegal}), 16'd0);
      chk("rst_dst", alu_dst, 16'h0000);
      chk("rst_src", alu_src, 16'h0000);
      chk("rst_ctl", {alu_oper, alu_func, alu_cond, 4'h0}, 16'h0000);
      chk("rst_r0", dbg_data, 16'h0000);
      // First instruction hand-timed: acceptance at edge k, operands after k+1, commit after k+2.
      stub(tbl[0]);
      @(negedge clk);
      instr = tbl[0].instr; instr_valid = 1'b1; sb.push_back(tbl[0]);
      @(negedge clk);
      instr_valid = 1'b0; instr = 16'hC000;
      chk("k0_ready", 16'(instr_ready), 16'd0);
      chk("k0_done", 16'(done), 16'd0);
      @(negedge clk);
      chk("k1_src", alu_src, 16'h007F);
      chk("k1_r3_unwritten", dbg_data, 16'h0000);
      chk("k1_done", 16'(done), 16'd0);
      @(negedge clk);
      chk("k2_done", 16'(done), 16'd1);
      chk("k2_ready", 16'(instr_ready), 16'd1);
      @(negedge clk);
      chk("k3_done_pulse", 16'(done), 16'd0);
      wait_drain("first");
      for (int i = 1; i < tbl.size(); i++) issue(tbl[i]);
      // Illegal immediately followed by a legal instruction on the next cycle.
      stub(mk(16'hD942, 16'h0042, 5'b0, 5'b0, 0, 16'h0, 16'h0042, 4'h9, 4'h9, 16'h0042, 5'b0));
      @(negedge clk);
      instr = 16'hC000; instr_valid = 1'b1;
      sb.push_back(mk(16'hC000, 16'h0, 5'b0, 5'b0, 1, 16'h0, 16'h0, 4'h0, 4'h9, 16'h0000, 5'b0));
      @(negedge clk);
      chk("b2b_ready", 16'(instr_ready), 16'd1);
      chk("b2b_illegal", 16'(illegal), 16'd1);
      instr = 16'hD942;
      sb.push_back(mk(16'hD942, 16'h0042, 5'b0, 5'b0, 0, 16'h0, 16'h0042, 4'h9, 4'h9, 16'h0042, 5'b0));
      @(negedge clk);
      instr_valid = 1'b0; instr = 16'h0;
      chk("b2b_illegal_pulse", 16'(illegal), 16'd0);
      chk("b2b_accepted", 16'(instr_ready), 16'd0);
      wait_drain("b2b");
      // Reset landing on the WB edge must abort the commit.
      stub(mk(16'h6605, 16'h0005, 5'b11111, 5'b11111, 0, 16'h0, 16'h0005, 4'h6, 4'h6, 16'h0, 5'b0));
      @(negedge clk);
      instr = 16'h6605; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("wbrst_src", alu_src, 16'h0005);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("wbrst_done", 16'(done), 16'd0);
      chk("wbrst_r6", dbg_data, 16'h0000);
      chk("wbrst_psr", 16'(psr), 16'd0);
      chk("wbrst_ready", 16'(instr_ready), 16'd1);
      @(negedge clk);
      chk("wbrst_done_late", 16'(done), 16'd0);
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
